fluid_vending_unit: RTL and testbench
=====================================

# fluid_vending_unit

Clocked fluid vending unit that combines a per-user visit tracker with a pricing and stock engine for three fluids. Each clock cycle out of reset is one purchase transaction. In that cycle the unit counts the user's visit, prices the requested volume with a loyalty discount based on visit count, and deducts stock or flags a restock. It sits behind the vending front-end; its registered outputs drive the display/billing logic.

## Interface
Parameters:
- RATE_WATER, 10: price per litre (Rs), fluid 2'b00
- RATE_JUICE, 30: price per litre, fluid 2'b01
- RATE_CHEM, 50: price per litre, fluid 2'b10
- STOCK_WATER, 100: initial/reset stock (L), water
- STOCK_JUICE, 50: initial/reset stock (L), juice
- STOCK_CHEM, 60: initial/reset stock (L), chemical

Ports:
- clk, input, 1: single clock; all state updates on rising edge
- reset, input, 1: synchronous, active-high
- user_id, input, 4: requesting user (16 users)
- fluid_type, input, 2: 00 water, 01 juice, 10 chemical, 11 invalid
- volume_l, input, 8: requested litres
- visits, output, 8: visit count of this transaction's user, including this visit
- original_price, output, 16: volume_l × rate
- discount_percent, output, 8: loyalty discount applied
- final_price, output, 16: price after discount
- remaining_qty, output, 16: stock of the selected fluid after this transaction
- message, output, 8: 0 OK, 1 restock needed, 2 invalid fluid

## Operation
- State:
  - 16 × 8-bit visit counters, indexed by user_id.
  - Three 16-bit stock registers.
  - All outputs registered.
- Every rising edge with reset low is one transaction for the current user_id/fluid_type/volume_l. There is no valid strobe.
- Visit counting:
  - n = count[user_id] + 1, saturating at 255; this value is written back to the counter.
  - visits = n for every transaction, including restock and invalid ones.
- Discount from n: 1 → 0, 2 → 5, 3 → 10, 4 → 15, ≥5 → 20.
- OK case (fluid valid and volume_l ≤ stock[fluid]):
  - original_price = volume_l × rate.
  - final_price = original_price − (original_price × discount)/100. Use a ≥18-bit intermediate product; the division truncates.
  - stock[fluid] -= volume_l; remaining_qty = new stock.
  - message = 0.
- Restock case (volume_l > stock[fluid]):
  - original_price, final_price and discount_percent all 0.
  - Stock is unchanged; remaining_qty = current stock.
  - message = 1.
- Invalid fluid (11):
  - All prices and discount 0, remaining_qty 0, message 2.
  - No stock is touched.
- volume_l = 0 is a legal OK transaction: prices 0, stock unchanged.
- Maximum original_price is 255 × 50 = 12750, which fits in 16 bits with no overflow.

## Timing
- Reset (synchronous, edge with reset=1):
  - All visit counters 0.
  - Stocks reload their parameter values.
  - All outputs 0.
  - No transaction is counted on a reset edge.
- Latency 1 cycle: outputs reflect the inputs sampled at the most recent rising edge and hold until the next edge.
- Back-to-back transactions occur every cycle. A same-user repeat sees the updated count; a same-fluid repeat sees the updated stock.
- Reset asserted mid-sequence discards all history; the first post-reset visit by any user reports visits=1.
- Counter saturation: user at 255 stays at 255 with discount 20.

## Test plan
- Reset, then user 1 / water / 1 L → visits 1, disc 0, orig 10, final 10, remaining 99, message 0.
- User 1 water 1, 2, 3, 4, 5 L on consecutive cycles from reset → fifth transaction: visits 5, disc 20, orig 50, final 40, remaining 85.
- User 2 juice 1, 2, 3 L → second: orig 60, disc 5, final 57; third: orig 90, disc 10, final 81, remaining 44.
- Juice 1 L at visit 2 (new user) → orig 30, disc 5, final 29 (truncation check).
- User 3 chemical 5, 10, 15, 20, 20 L:
  - First four → remaining 55, 45, 30, 10; fourth has orig 1000, disc 15, final 850.
  - Fifth → message 1, visits 5, prices and discount 0, remaining 10.
- fluid_type 11, 3 L → message 2, prices 0, remaining 0, visit still counted.
- After traffic, assert reset one cycle, then user 1 water 2 L → visits 1, final 20, remaining 98.

Source files
------------

// File: rtl/fluid_vending_unit.sv
// One purchase transaction per clock: visit counting, loyalty-discounted pricing and stock deduction for three fluids.
// Outputs are registered, one cycle of latency; no backpressure, a new transaction is accepted on every edge.
module fluid_vending_unit #(
    parameter int unsigned RATE_WATER  = 10,
    parameter int unsigned RATE_JUICE  = 30,
    parameter int unsigned RATE_CHEM   = 50,
    parameter int unsigned STOCK_WATER = 100,
    parameter int unsigned STOCK_JUICE = 50,
    parameter int unsigned STOCK_CHEM  = 60
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [3:0]  user_id_i,
    input  logic [1:0]  fluid_type_i,
    input  logic [7:0]  volume_l_i,
    output logic [7:0]  visits_o,
    output logic [15:0] original_price_o,
    output logic [7:0]  discount_percent_o,
    output logic [15:0] final_price_o,
    output logic [15:0] remaining_qty_o,
    output logic [7:0]  message_o
);

    localparam logic [1:0] FT_WATER = 2'b00;
    localparam logic [1:0] FT_JUICE = 2'b01;
    localparam logic [1:0] FT_CHEM  = 2'b10;

    localparam logic [7:0] MSG_OK      = 8'd0;
    localparam logic [7:0] MSG_RESTOCK = 8'd1;
    localparam logic [7:0] MSG_INVALID = 8'd2;

    logic [7:0]  count_q [16];
    logic [15:0] water_q, juice_q, chem_q;

    logic [7:0]  visits_q, discount_q, message_q;
    logic [15:0] orig_q, final_q, remain_q;

    logic [7:0]  visits_d, discount_d, message_d, disc_n;
    logic [15:0] orig_d, final_d, remain_d;
    logic [15:0] rate, stock_sel, stock_new, vol16, disc_amt;
    logic [23:0] prod;
    logic        fluid_ok, stock_ok;

    always_comb begin
        visits_d   = (count_q[user_id_i] == 8'hFF) ? 8'hFF : count_q[user_id_i] + 8'd1;
        discount_d = 8'd0;
        message_d  = MSG_OK;
        orig_d     = 16'd0;
        final_d    = 16'd0;
        remain_d   = 16'd0;
        rate       = 16'd0;
        stock_sel  = 16'd0;
        fluid_ok   = 1'b1;

        case (visits_d)
            8'd1:    disc_n = 8'd0;
            8'd2:    disc_n = 8'd5;
            8'd3:    disc_n = 8'd10;
            8'd4:    disc_n = 8'd15;
            default: disc_n = 8'd20;
        endcase

        case (fluid_type_i)
            FT_WATER: begin rate = 16'(RATE_WATER); stock_sel = water_q; end
            FT_JUICE: begin rate = 16'(RATE_JUICE); stock_sel = juice_q; end
            FT_CHEM:  begin rate = 16'(RATE_CHEM);  stock_sel = chem_q;  end
            default:  fluid_ok = 1'b0;
        endcase

        vol16     = {8'd0, volume_l_i};
        stock_ok  = fluid_ok && (vol16 <= stock_sel);
        stock_new = stock_sel - vol16;
        // Worst case 12750 * 20 needs 18 bits; truncating divide matches billing rules.
        prod      = {8'd0, vol16 * rate} * {16'd0, disc_n};
        disc_amt  = 16'(prod / 24'd100);

        if (!fluid_ok) begin
            message_d = MSG_INVALID;
        end else if (stock_ok) begin
            discount_d = disc_n;
            orig_d     = vol16 * rate;
            final_d    = orig_d - disc_amt;
            remain_d   = stock_new;
        end else begin
            message_d = MSG_RESTOCK;
            remain_d  = stock_sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 16; i++) count_q[i] <= 8'd0;
            water_q    <= 16'(STOCK_WATER);
            juice_q    <= 16'(STOCK_JUICE);
            chem_q     <= 16'(STOCK_CHEM);
            visits_q   <= 8'd0;
            discount_q <= 8'd0;
            message_q  <= 8'd0;
            orig_q     <= 16'd0;
            final_q    <= 16'd0;
            remain_q   <= 16'd0;
        end else begin
            count_q[user_id_i] <= visits_d;
            if (stock_ok) begin
                case (fluid_type_i)
                    FT_WATER: water_q <= stock_new;
                    FT_JUICE: juice_q <= stock_new;
                    default:  chem_q  <= stock_new;
                endcase
            end
            visits_q   <= visits_d;
            discount_q <= discount_d;
            message_q  <= message_d;
            orig_q     <= orig_d;
            final_q    <= final_d;
            remain_q   <= remain_d;
        end
    end

    assign visits_o           = visits_q;
    assign original_price_o   = orig_q;
    assign discount_percent_o = discount_q;
    assign final_price_o      = final_q;
    assign remaining_qty_o    = remain_q;
    assign message_o          = message_q;

endmodule

// File: tb/tb_fluid_vending_unit.sv
// Directed bench: each driven cycle pushes its hand-computed response; a monitor pops and compares after each edge.
module tb_fluid_vending_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  user_id;
    logic [1:0]  fluid_type;
    logic [7:0]  volume_l;
    logic [7:0]  visits, discount_percent, message;
    logic [15:0] original_price, final_price, remaining_qty;

    typedef struct packed {
        logic [7:0]  visits;
        logic [7:0]  disc;
        logic [15:0] orig;
        logic [15:0] fin;
        logic [15:0] rem;
        logic [7:0]  msg;
    } exp_t;

    typedef struct {
        string name;
        exp_t  e;
    } item_t;

    item_t q[$];
    int    tests  = 0;
    int    failed = 0;

    always #5 clk = ~clk;

    fluid_vending_unit dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .user_id_i          (user_id),
        .fluid_type_i       (fluid_type),
        .volume_l_i         (volume_l),
        .visits_o           (visits),
        .original_price_o   (original_price),
        .discount_percent_o (discount_percent),
        .final_price_o      (final_price),
        .remaining_qty_o    (remaining_qty),
        .message_o          (message)
    );

    // Monitor: outputs settle one edge after the stimulus was applied.
    initial begin
        item_t it;
        exp_t  act;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                it  = q.pop_front();
                act = '{visits, discount_percent, original_price, final_price, remaining_qty, message};
                tests++;
                if (act !== it.e) begin
                    failed++;
                    $display("FAIL %s: got visits=%0d disc=%0d orig=%0d final=%0d rem=%0d msg=%0d, want visits=%0d disc=%0d orig=%0d final=%0d rem=%0d msg=%0d",
                             it.name, act.visits, act.disc, act.orig, act.fin, act.rem, act.msg,
                             it.e.visits, it.e.disc, it.e.orig, it.e.fin, it.e.rem, it.e.msg);
                end
            end
        end
    end

    task automatic do_reset(input string name);
        item_t it;
        @(negedge clk);
        reset = 1'b1;
        it.name = name;
        it.e    = '0;
        q.push_back(it);
    endtask

    task automatic txn(input string name, input logic [3:0] u, input logic [1:0] f, input logic [7:0] v,
                       input int ev, input int ed, input int eo, input int ef, input int er, input int em);
        item_t it;
        @(negedge clk);
        reset      = 1'b0;
        user_id    = u;
        fluid_type = f;
        volume_l   = v;
        it.name = name;
        it.e    = '{8'(ev), 8'(ed), 16'(eo), 16'(ef), 16'(er), 8'(em)};
        q.push_back(it);
    endtask

    initial begin
        int budget;
        reset = 1'b1; user_id = '0; fluid_type = '0; volume_l = '0;

        do_reset("reset_state");
        // user 1 water ramp from reset
        txn("u1_w1", 4'd1, 2'b00, 8'd1, 1,  0, 10, 10, 99, 0);
        txn("u1_w2", 4'd1, 2'b00, 8'd2, 2,  5, 20, 19, 97, 0);
        txn("u1_w3", 4'd1, 2'b00, 8'd3, 3, 10, 30, 27, 94, 0);
        txn("u1_w4", 4'd1, 2'b00, 8'd4, 4, 15, 40, 34, 90, 0);
        txn("u1_w5", 4'd1, 2'b00, 8'd5, 5, 20, 50, 40, 85, 0);
        // user 2 juice
        txn("u2_j1", 4'd2, 2'b01, 8'd1, 1,  0, 30, 30, 49, 0);
        txn("u2_j2", 4'd2, 2'b01, 8'd2, 2,  5, 60, 57, 47, 0);
        txn("u2_j3", 4'd2, 2'b01, 8'd3, 3, 10, 90, 81, 44, 0);
        // truncation: 30 * 5 / 100 = 1
        txn("u4_j1", 4'd4, 2'b01, 8'd1, 1,  0, 30, 30, 43, 0);
        txn("u4_trunc", 4'd4, 2'b01, 8'd1, 2, 5, 30, 29, 42, 0);
        // user 3 chemical, ending in restock
        txn("u3_c5",  4'd3, 2'b10, 8'd5,  1,  0,  250,  250, 55, 0);
        txn("u3_c10", 4'd3, 2'b10, 8'd10, 2,  5,  500,  475, 45, 0);
        txn("u3_c15", 4'd3, 2'b10, 8'd15, 3, 10,  750,  675, 30, 0);
        txn("u3_c20", 4'd3, 2'b10, 8'd20, 4, 15, 1000,  850, 10, 0);
        txn("u3_restock", 4'd3, 2'b10, 8'd20, 5, 0, 0, 0, 10, 1);
        // invalid fluid, zero volume, exact-stock drain, then restock on empty
        txn("u5_invalid", 4'd5, 2'b11, 8'd3,  1,  0,   0,   0,  0, 2);
        txn("u5_zero",    4'd5, 2'b00, 8'd0,  2,  5,   0,   0, 85, 0);
        txn("u5_exact",   4'd5, 2'b00, 8'd85, 3, 10, 850, 765,  0, 0);
        txn("u5_empty",   4'd5, 2'b00, 8'd1,  4,  0,   0,   0,  0, 1);
        // visit counter saturation on invalid traffic, no stock touched
        for (int i = 1; i <= 258; i++)
            txn($sformatf("u6_sat%0d", i), 4'd6, 2'b11, 8'd7, (i > 255) ? 255 : i, 0, 0, 0, 0, 2);
        txn("u6_sat_disc", 4'd6, 2'b01, 8'd10, 255, 20, 300, 240, 32, 0);
        // mid-sequence reset discards history and stock
        do_reset("mid_reset");
        txn("post_u1_w2", 4'd1, 2'b00, 8'd2, 1, 0, 20, 20, 98, 0);
        txn("post_u6_j1", 4'd6, 2'b01, 8'd1, 1, 0, 30, 30, 49, 0);
        txn("post_u3_c255", 4'd3, 2'b10, 8'd255, 1, 0, 0, 0, 60, 1);

        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expected responses never checked, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
